// File: rtl/dca_matrix_lsu_row_sequencer_if.sv
// Instruction and memory-request bundle for the matrix LSU row sequencer.
// The sequencer itself binds the master modport; its environment binds slave.
interface dca_matrix_lsu_row_sequencer_if #(
  parameter int BW_ADDR = 32,
  parameter int BW_DIM  = 4
);
  logic               inst_valid;
  logic               inst_ready;
  logic               inst_write;
  logic [BW_ADDR-1:0] inst_addr;
  logic [BW_ADDR-1:0] inst_stride;
  logic [BW_DIM-1:0]  inst_num_row;
  logic [BW_DIM-1:0]  inst_num_col;
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [BW_ADDR-1:0] req_addr;
  logic [BW_ADDR-1:0] req_size;
  logic               req_last;
  logic               resp_valid;

  modport master (
    input  inst_valid,
    output inst_ready,
    input  inst_write,
    input  inst_addr,
    input  inst_stride,
    input  inst_num_row,
    input  inst_num_col,
    output req_valid,
    input  req_ready,
    output req_write,
    output req_addr,
    output req_size,
    output req_last,
    input  resp_valid
  );

  modport slave (
    output inst_valid,
    input  inst_ready,
    output inst_write,
    output inst_addr,
    output inst_stride,
    output inst_num_row,
    output inst_num_col,
    input  req_valid,
    output req_ready,
    input  req_write,
    input  req_addr,
    input  req_size,
    input  req_last,
    output resp_valid
  );
endinterface

// File: rtl/dca_matrix_lsu_row_sequencer.sv
// Expands one matrix LSU instruction into per-row memory requests and
// tracks row completions, pulsing done once the whole block has landed.
module dca_matrix_lsu_row_sequencer #(
  parameter int BW_ADDR         = 32,
  parameter int MAX_DIM         = 8,
  parameter int BW_DIM          = 4,
  parameter int ELEM_BYTES      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rstnn,
  input  logic enable,
  input  logic clear,
  dca_matrix_lsu_row_sequencer_if.master bus,
  output logic busy,
  output logic done,
  output logic err_underflow
);

  localparam int BW_OUT = 4;

  if (MAX_DIM >= (1 << BW_DIM)) begin : g_dim_chk
    $error("BW_DIM too narrow for MAX_DIM");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_out_chk
    $error("MAX_OUTSTANDING out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_e;

  state_e             state_q;
  logic               write_q;
  logic [BW_ADDR-1:0] addr_q;
  logic [BW_ADDR-1:0] stride_q;
  logic [BW_DIM-1:0]  nrow_q;
  logic [BW_DIM-1:0]  ncol_q;
  logic [BW_DIM-1:0]  row_idx_q;
  logic [BW_OUT-1:0]  out_q;
  logic               err_q;

  logic can_issue;
  logic last_row;
  logic acc;
  logic hs;
  logic rsp;

  // Handshake qualifiers derived from registered state and enable.
  always_comb begin
    can_issue = out_q < BW_OUT'(MAX_OUTSTANDING);
    last_row  = row_idx_q == BW_DIM'(nrow_q - BW_DIM'(1));
    bus.inst_ready = enable & (state_q == IDLE);
    bus.req_valid  = enable & (state_q == ISSUE) & can_issue;
    acc = bus.inst_valid & bus.inst_ready;
    hs  = bus.req_valid & bus.req_ready;
    rsp = enable & bus.resp_valid;
  end

  assign bus.req_write  = write_q;
  assign bus.req_addr   = addr_q;
  assign bus.req_size   = BW_ADDR'(ncol_q) * BW_ADDR'(ELEM_BYTES);
  assign bus.req_last   = last_row;
  assign busy           = state_q != IDLE;
  assign done           = enable & (state_q == FINISH);
  assign err_underflow  = err_q;

  // Sequencer FSM with outstanding-row accounting; clear wins over events.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      stride_q  <= '0;
      nrow_q    <= '0;
      ncol_q    <= '0;
      row_idx_q <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else if (enable) begin
      if (clear) begin
        state_q   <= IDLE;
        row_idx_q <= '0;
        out_q     <= '0;
        err_q     <= 1'b0;
      end else begin
        if (hs && !rsp) begin
          out_q <= out_q + BW_OUT'(1);
        end else if (!hs && rsp) begin
          if (out_q == '0) err_q <= 1'b1;
          else             out_q <= out_q - BW_OUT'(1);
        end
        unique case (state_q)
          IDLE: begin
            if (acc) begin
              write_q   <= bus.inst_write;
              addr_q    <= bus.inst_addr;
              stride_q  <= bus.inst_stride;
              nrow_q    <= bus.inst_num_row;
              ncol_q    <= bus.inst_num_col;
              row_idx_q <= '0;
              if (bus.inst_num_row == '0 || bus.inst_num_col == '0)
                state_q <= FINISH;
              else
                state_q <= ISSUE;
            end
          end
          ISSUE: begin
            if (hs) begin
              addr_q    <= addr_q + stride_q;
              row_idx_q <= row_idx_q + BW_DIM'(1);
              if (last_row) state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (out_q == '0) state_q <= FINISH;
          end
          FINISH: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dca_matrix_lsu_row_sequencer.sv
// Directed bench for the matrix LSU row sequencer.
// Each task drives one scenario and checks against hand-derived values.
module tb_dca_matrix_lsu_row_sequencer;

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  logic enable = 1'b1;
  logic clear = 1'b0;
  logic busy;
  logic done;
  logic err_underflow;
  int   pass_cnt = 0;
  int   tot_cnt = 0;

  dca_matrix_lsu_row_sequencer_if #(.BW_ADDR(32), .BW_DIM(4)) bus ();

  dca_matrix_lsu_row_sequencer dut (
    .clk           (clk),
    .rstnn         (rstnn),
    .enable        (enable),
    .clear         (clear),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] s, input logic [3:0] r,
                      input logic [3:0] c);
    bus.inst_valid   = 1'b1;
    bus.inst_write   = w;
    bus.inst_addr    = a;
    bus.inst_stride  = s;
    bus.inst_num_row = r;
    bus.inst_num_col = c;
    #1;
    tot_cnt++;
    if (bus.inst_ready !== 1'b1)
      $display("FAIL accept: inst_ready got %b want 1", bus.inst_ready);
    else pass_cnt++;
    tick;
    bus.inst_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstnn = 1'b0;
    tick;
    tick;
    rstnn = 1'b1;
    #1;
    tot_cnt++;
    if ({bus.inst_ready, bus.req_valid, busy, done, err_underflow}
        !== 5'b10000)
      $display("FAIL reset: ready/rv/busy/done/err got %b want 10000",
               {bus.inst_ready, bus.req_valid, busy, done, err_underflow});
    else pass_cnt++;
  endtask

  task automatic test_read;
    bit sched [64];
    int n = 0;
    int ndone = 0;
    int dcyc = -1;
    int lresp = -1;
    logic [65:0] got;
    logic [65:0] exp;
    bus.req_ready = 1'b1;
    send(1'b0, 32'h1000, 32'h40, 4'd3, 4'd8);
    for (int c = 1; c < 20; c++) begin
      bus.resp_valid = sched[c];
      if (sched[c]) lresp = c;
      #1;
      if (done) begin
        ndone++;
        dcyc = c;
      end
      if (bus.req_valid) begin
        got = {bus.req_addr, bus.req_size, bus.req_last, bus.req_write};
        exp = {32'h1000 + 32'(n) * 32'h40, 32'd32, (n == 2), 1'b0};
        tot_cnt++;
        if (got !== exp)
          $display("FAIL read_row%0d: got %h want %h", n, got, exp);
        else pass_cnt++;
        sched[c + 2] = 1'b1;
        n++;
      end
      tick;
    end
    bus.resp_valid = 1'b0;
    tot_cnt++;
    if (n !== 3) $display("FAIL read_nreq: got %0d want 3", n);
    else pass_cnt++;
    tot_cnt++;
    if (ndone !== 1) $display("FAIL read_ndone: got %0d want 1", ndone);
    else pass_cnt++;
    tot_cnt++;
    if (dcyc !== lresp + 2)
      $display("FAIL read_done_cyc: got %0d want %0d", dcyc, lresp + 2);
    else pass_cnt++;
  endtask

  task automatic test_limit;
    int n = 0;
    int iss;
    int giv;
    bit seen = 1'b0;
    bus.req_ready = 1'b1;
    send(1'b1, 32'h4000, 32'h100, 4'd8, 4'd2);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.req_valid) n++;
      tick;
    end
    tot_cnt++;
    if (n !== 4) $display("FAIL limit_count: got %0d want 4", n);
    else pass_cnt++;
    bus.resp_valid = 1'b1;
    #1;
    tot_cnt++;
    if (bus.req_valid !== 1'b0)
      $display("FAIL limit_hold: req_valid got %b want 0", bus.req_valid);
    else pass_cnt++;
    tick;
    bus.resp_valid = 1'b1;
    #1;
    tot_cnt++;
    if ({bus.req_valid, bus.req_addr, bus.req_write} !== {1'b1, 32'h4400, 1'b1})
      $display("FAIL limit_row4: got %b/%h/%b want 1/00004400/1",
               bus.req_valid, bus.req_addr, bus.req_write);
    else pass_cnt++;
    tick;
    bus.resp_valid = 1'b0;
    #1;
    tot_cnt++;
    if ({bus.req_valid, bus.req_addr} !== {1'b1, 32'h4500})
      $display("FAIL simul_keep: got %b/%h want 1/00004500",
               bus.req_valid, bus.req_addr);
    else pass_cnt++;
    tick;
    #1;
    tot_cnt++;
    if (bus.req_valid !== 1'b0)
      $display("FAIL simul_full: req_valid got %b want 0", bus.req_valid);
    else pass_cnt++;
    iss = 6;
    giv = 2;
    for (int c = 0; c < 40 && !seen; c++) begin
      bus.resp_valid = (giv < iss);
      #1;
      if (done) seen = 1'b1;
      else begin
        if (bus.req_valid) iss++;
        if (bus.resp_valid) giv++;
        tick;
      end
    end
    bus.resp_valid = 1'b0;
    tot_cnt++;
    if ({seen, 8'(iss), 8'(giv), err_underflow} !== {1'b1, 8'd8, 8'd8, 1'b0})
      $display("FAIL limit_done: seen/iss/resp/err got %b/%0d/%0d/%b want 1/8/8/0",
               seen, iss, giv, err_underflow);
    else pass_cnt++;
    tick;
  endtask

  task automatic test_zero;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) send(1'b0, 32'h100, 32'h10, 4'd0, 4'd8);
      else        send(1'b1, 32'h100, 32'h10, 4'd3, 4'd0);
      #1;
      tot_cnt++;
      if ({bus.req_valid, done, bus.inst_ready, busy} !== 4'b0101)
        $display("FAIL zero%0d_c1: rv/done/ready/busy got %b want 0101", k,
                 {bus.req_valid, done, bus.inst_ready, busy});
      else pass_cnt++;
      tick;
      tot_cnt++;
      if ({bus.req_valid, done, bus.inst_ready, busy} !== 4'b0010)
        $display("FAIL zero%0d_c2: rv/done/ready/busy got %b want 0010", k,
                 {bus.req_valid, done, bus.inst_ready, busy});
      else pass_cnt++;
    end
  endtask

  task automatic test_stall_wrap;
    bit stable = 1'b1;
    bit seen = 1'b0;
    bus.req_ready = 1'b0;
    send(1'b0, 32'hFFFF_FFC0, 32'h40, 4'd2, 4'd1);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (!(bus.req_valid === 1'b1 && bus.req_addr === 32'hFFFF_FFC0 &&
            bus.req_last === 1'b0))
        stable = 1'b0;
      tick;
    end
    tot_cnt++;
    if (stable !== 1'b1) $display("FAIL stall_stable: got %b want 1", stable);
    else pass_cnt++;
    bus.req_ready = 1'b1;
    tick;
    #1;
    tot_cnt++;
    if ({bus.req_valid, bus.req_addr, bus.req_last, bus.req_size}
        !== {1'b1, 32'h0, 1'b1, 32'd4})
      $display("FAIL wrap_row1: got %b/%h/%b/%0d want 1/00000000/1/4",
               bus.req_valid, bus.req_addr, bus.req_last, bus.req_size);
    else pass_cnt++;
    tick;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b1;
    tick;
    tick;
    bus.resp_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (done) seen = 1'b1;
      else tick;
    end
    tot_cnt++;
    if ({seen, err_underflow} !== 2'b10)
      $display("FAIL wrap_done: seen/err got %b want 10", {seen, err_underflow});
    else pass_cnt++;
    tick;
  endtask

  task automatic test_clear;
    bit seen = 1'b0;
    bus.req_ready = 1'b1;
    send(1'b0, 32'h8000, 32'h20, 4'd8, 4'd4);
    tick;
    tick;
    #1;
    tot_cnt++;
    if ({bus.req_valid, bus.req_addr} !== {1'b1, 32'h8040})
      $display("FAIL clear_pre: got %b/%h want 1/00008040",
               bus.req_valid, bus.req_addr);
    else pass_cnt++;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    #1;
    tot_cnt++;
    if ({busy, bus.req_valid, done, bus.inst_ready} !== 4'b0001)
      $display("FAIL clear_idle: busy/rv/done/ready got %b want 0001",
               {busy, bus.req_valid, done, bus.inst_ready});
    else pass_cnt++;
    send(1'b1, 32'h2000, 32'h10, 4'd1, 4'd2);
    #1;
    tot_cnt++;
    if ({bus.req_valid, bus.req_addr, bus.req_last, bus.req_write, bus.req_size}
        !== {1'b1, 32'h2000, 1'b1, 1'b1, 32'd8})
      $display("FAIL after_clear: got %b/%h/%b/%b/%0d want 1/00002000/1/1/8",
               bus.req_valid, bus.req_addr, bus.req_last, bus.req_write,
               bus.req_size);
    else pass_cnt++;
    tick;
    bus.resp_valid = 1'b1;
    tick;
    bus.resp_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (done) seen = 1'b1;
      else tick;
    end
    tot_cnt++;
    if ({seen, err_underflow} !== 2'b10)
      $display("FAIL after_clear_done: seen/err got %b want 10",
               {seen, err_underflow});
    else pass_cnt++;
    tick;
    bus.resp_valid = 1'b1;
    tick;
    bus.resp_valid = 1'b0;
    tick;
    tick;
    tot_cnt++;
    if (err_underflow !== 1'b1)
      $display("FAIL underflow_set: got %b want 1", err_underflow);
    else pass_cnt++;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    tot_cnt++;
    if (err_underflow !== 1'b0)
      $display("FAIL underflow_clr: got %b want 0", err_underflow);
    else pass_cnt++;
  endtask

  task automatic test_enable;
    enable = 1'b0;
    bus.resp_valid = 1'b1;
    #1;
    tot_cnt++;
    if ({bus.inst_ready, bus.req_valid} !== 2'b00)
      $display("FAIL enable_off: ready/rv got %b want 00",
               {bus.inst_ready, bus.req_valid});
    else pass_cnt++;
    tick;
    tick;
    bus.resp_valid = 1'b0;
    enable = 1'b1;
    #1;
    tot_cnt++;
    if ({bus.inst_ready, err_underflow} !== 2'b10)
      $display("FAIL enable_on: ready/err got %b want 10",
               {bus.inst_ready, err_underflow});
    else pass_cnt++;
  endtask

  initial begin
    bus.inst_valid   = 1'b0;
    bus.inst_write   = 1'b0;
    bus.inst_addr    = '0;
    bus.inst_stride  = '0;
    bus.inst_num_row = '0;
    bus.inst_num_col = '0;
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    test_reset;
    test_read;
    test_limit;
    test_zero;
    test_stall_wrap;
    test_clear;
    test_enable;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
